boot_flash_streamer: RTL

- Upstream feeder for the SRAM bootstrap loader.
- Reads a boot image from the on-board SPI flash: 0x03 READ command, 24-bit address.
- Validates the image's 6-byte header: start lo/mid/hi, end lo/mid/hi, 18-bit addresses little-endian.
- Re-transmits header plus data as an SPI master into the bootstrap SPI slave port as one SSEL-framed message.

---
 rtl/boot_pkg.sv | 35 +++
 rtl/spi_byte_engine.sv | 67 ++++++
 rtl/boot_flash_streamer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the boot flash streamer and its SPI byte engines.
package boot_pkg;

    localparam logic [7:0]  FLASH_CMD_READ = 8'h03;
    localparam int unsigned HDR_LEN        = 6;
    localparam int unsigned ADDR_W         = 18;

    // Top-level sequencer states; BT_LEAD is the idle lead-in after boot_SSEL falls.
    typedef enum logic [3:0] {
        IDLE,
        FL_CMD,
        FL_HDR,
        CHECK,
        BT_LEAD,
        BT_HDR,
        FL_READ,
        BT_SEND,
        FINISH
    } state_t;

    // Per-byte sub-phase: launch the engine, wait for it, then idle gap (boot link only).
    typedef enum logic [1:0] {
        PH_GO,
        PH_WAIT,
        PH_GAP
    } phase_t;

    // Assemble an 18-bit little-endian header address.
    function automatic logic [ADDR_W-1:0] hdr_addr(input logic [7:0] lo,
                                                   input logic [7:0] mid,
                                                   input logic [1:0] hi);
        return {hi, mid, lo};
    endfunction

endpackage

// File: rtl/spi_byte_engine.sv
// Mode-0 SPI master byte shifter: MSB first, SCK idles low, CLKDIV clk half-period.
module spi_byte_engine #(
    parameter int unsigned CLKDIV = 4
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       start,
    input  logic [7:0] tx_byte,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_byte,
    output logic       sck,
    output logic       mosi,
    input  logic       miso
);

    localparam int unsigned    DIV_W    = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       half_cnt;
    logic [7:0]       tx_sh;

    // Half-period timer; MOSI changes on falling edges, MISO is sampled on rising edges.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_byte  <= '0;
            sck      <= 1'b0;
            mosi     <= 1'b0;
            div_cnt  <= '0;
            half_cnt <= '0;
            tx_sh    <= '0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    busy     <= 1'b1;
                    tx_sh    <= tx_byte;
                    mosi     <= tx_byte[7];
                    div_cnt  <= '0;
                    half_cnt <= '0;
                    sck      <= 1'b0;
                end
            end else if (div_cnt == DIV_LAST) begin
                div_cnt  <= '0;
                half_cnt <= half_cnt + 4'd1;
                if (!sck) begin
                    sck     <= 1'b1;
                    rx_byte <= {rx_byte[6:0], miso};
                end else begin
                    sck   <= 1'b0;
                    tx_sh <= {tx_sh[6:0], 1'b0};
                    mosi  <= tx_sh[6];
                end
                if (half_cnt == 4'd15) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/boot_flash_streamer.sv
// Reads a boot image from SPI flash, validates its header and re-sends it to the bootstrap port.
module boot_flash_streamer
    import boot_pkg::*;
#(
    parameter logic [23:0] FLASH_OFFSET = 24'h030000,
    parameter int unsigned CLKDIV       = 4,
    parameter int unsigned GAP_CLKS     = 16
) (
    input  logic clk,
    input  logic reset_b,
    input  logic start,
    output logic busy,
    output logic done,
    output logic error,
    output logic flash_SCK,
    output logic flash_SSEL,
    output logic flash_MOSI,
    input  logic flash_MISO,
    output logic boot_SCK,
    output logic boot_SSEL,
    output logic boot_MOSI
);

    localparam int unsigned    GAP_W     = 16;
    localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_CLKS - 1);
    localparam logic [GAP_W-1:0] HOLD_LOAD = GAP_W'(2 * CLKDIV - 1);
    localparam logic [2:0]     HDR_LAST  = 3'(HDR_LEN - 1);

    state_t state, state_next;
    phase_t phase, phase_next;

    logic [2:0]        idx, idx_next;
    logic [GAP_W-1:0]  gap_cnt, gap_next;
    logic [ADDR_W-1:0] count, count_next;
    logic [7:0]        hdr [HDR_LEN];
    logic [7:0]        data_buf;

    logic [ADDR_W-1:0] start_addr, end_addr;
    logic              hdr_bad;
    logic [7:0]        cmd_byte;

    logic       fl_start, fl_busy, fl_done;
    logic [7:0] fl_tx, fl_rx;
    logic       bt_start, bt_busy, bt_done;
    logic [7:0] bt_tx, bt_rx_unused;

    logic hdr_we, buf_we, flags_clr, done_set, err_set;

    spi_byte_engine #(.CLKDIV(CLKDIV)) u_flash_spi (
        .clk     (clk),
        .reset_b (reset_b),
        .start   (fl_start),
        .tx_byte (fl_tx),
        .busy    (fl_busy),
        .done    (fl_done),
        .rx_byte (fl_rx),
        .sck     (flash_SCK),
        .mosi    (flash_MOSI),
        .miso    (flash_MISO)
    );

    spi_byte_engine #(.CLKDIV(CLKDIV)) u_boot_spi (
        .clk     (clk),
        .reset_b (reset_b),
        .start   (bt_start),
        .tx_byte (bt_tx),
        .busy    (bt_busy),
        .done    (bt_done),
        .rx_byte (bt_rx_unused),
        .sck     (boot_SCK),
        .mosi    (boot_MOSI),
        .miso    (1'b0)
    );

    assign start_addr = hdr_addr(hdr[0], hdr[1], hdr[2][1:0]);
    assign end_addr   = hdr_addr(hdr[3], hdr[4], hdr[5][1:0]);
    assign hdr_bad    = (hdr[2][7:2] != '0) || (hdr[5][7:2] != '0) || (end_addr < start_addr);

    // READ command followed by the three flash address bytes.
    always_comb begin
        case (idx)
            3'd0:    cmd_byte = FLASH_CMD_READ;
            3'd1:    cmd_byte = FLASH_OFFSET[23:16];
            3'd2:    cmd_byte = FLASH_OFFSET[15:8];
            default: cmd_byte = FLASH_OFFSET[7:0];
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state, engine launches and datapath strobes.
    always_comb begin
        state_next = state;
        phase_next = phase;
        idx_next   = idx;
        gap_next   = gap_cnt;
        count_next = count;
        fl_start   = 1'b0;
        bt_start   = 1'b0;
        fl_tx      = (state == FL_CMD) ? cmd_byte : 8'h00;
        bt_tx      = (state == BT_SEND) ? data_buf : hdr[idx];
        hdr_we     = 1'b0;
        buf_we     = 1'b0;
        flags_clr  = 1'b0;
        done_set   = 1'b0;
        err_set    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = FL_CMD;
                    phase_next = PH_GO;
                    idx_next   = '0;
                    flags_clr  = 1'b1;
                end
            end

            FL_CMD, FL_HDR: begin
                case (phase)
                    PH_GO: begin
                        if (!fl_busy) begin
                            fl_start   = 1'b1;
                            phase_next = PH_WAIT;
                        end
                    end
                    PH_WAIT: begin
                        if (fl_done) begin
                            phase_next = PH_GO;
                            if (state == FL_CMD) begin
                                if (idx == 3'd3) begin
                                    idx_next   = '0;
                                    state_next = FL_HDR;
                                end else begin
                                    idx_next = idx + 3'd1;
                                end
                            end else begin
                                hdr_we = 1'b1;
                                if (idx == HDR_LAST) begin
                                    idx_next   = '0;
                                    state_next = CHECK;
                                end else begin
                                    idx_next = idx + 3'd1;
                                end
                            end
                        end
                    end
                    default: phase_next = PH_GO;
                endcase
            end

            CHECK: begin
                if (hdr_bad) begin
                    err_set    = 1'b1;
                    state_next = IDLE;
                end else begin
                    count_next = end_addr - start_addr;
                    gap_next   = GAP_LOAD;
                    state_next = BT_LEAD;
                end
            end

            BT_LEAD: begin
                if (gap_cnt == '0) begin
                    state_next = BT_HDR;
                    phase_next = PH_GO;
                    idx_next   = '0;
                end else begin
                    gap_next = gap_cnt - GAP_W'(1);
                end
            end

            BT_HDR, BT_SEND: begin
                case (phase)
                    PH_GO: begin
                        if (!bt_busy) begin
                            bt_start   = 1'b1;
                            phase_next = PH_WAIT;
                        end
                    end
                    PH_WAIT: begin
                        if (bt_done) begin
                            phase_next = PH_GAP;
                            gap_next   = GAP_LOAD;
                        end
                    end
                    default: begin
                        if (gap_cnt != '0) begin
                            gap_next = gap_cnt - GAP_W'(1);
                        end else if (state == BT_HDR) begin
                            phase_next = PH_GO;
                            if (idx == HDR_LAST) begin
                                state_next = FL_READ;
                            end else begin
                                idx_next = idx + 3'd1;
                            end
                        end else if (count == '0) begin
                            state_next = FINISH;
                            gap_next   = HOLD_LOAD;
                        end else begin
                            count_next = count - ADDR_W'(1);
                            state_next = FL_READ;
                            phase_next = PH_GO;
                        end
                    end
                endcase
            end

            FL_READ: begin
                case (phase)
                    PH_GO: begin
                        if (!fl_busy) begin
                            fl_start   = 1'b1;
                            phase_next = PH_WAIT;
                        end
                    end
                    PH_WAIT: begin
                        if (fl_done) begin
                            buf_we     = 1'b1;
                            state_next = BT_SEND;
                            phase_next = PH_GO;
                        end
                    end
                    default: phase_next = PH_GO;
                endcase
            end

            FINISH: begin
                if (gap_cnt == '0) begin
                    done_set   = 1'b1;
                    state_next = IDLE;
                end else begin
                    gap_next = gap_cnt - GAP_W'(1);
                end
            end

            default: state_next = IDLE;
        endcase
    end

    // Datapath registers, sticky flags and registered chip selects (decoded from the next state).
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            phase      <= PH_GO;
            idx        <= '0;
            gap_cnt    <= '0;
            count      <= '0;
            data_buf   <= '0;
            for (int unsigned i = 0; i < HDR_LEN; i++) hdr[i] <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            flash_SSEL <= 1'b1;
            boot_SSEL  <= 1'b1;
        end else begin
            phase   <= phase_next;
            idx     <= idx_next;
            gap_cnt <= gap_next;
            count   <= count_next;
            if (hdr_we) hdr[idx] <= fl_rx;
            if (buf_we) data_buf <= fl_rx;
            if (flags_clr) begin
                done  <= 1'b0;
                error <= 1'b0;
            end
            if (done_set) done <= 1'b1;
            if (err_set)  error <= 1'b1;
            busy       <= (state_next != IDLE);
            flash_SSEL <= !(state_next inside {FL_CMD, FL_HDR, CHECK, BT_LEAD, BT_HDR, FL_READ, BT_SEND});
            boot_SSEL  <= !(state_next inside {BT_LEAD, BT_HDR, FL_READ, BT_SEND});
        end
    end

endmodule
